// File: rtl/stream_pkg.sv
// Shared definitions for the stream FIFO: default sizes, pointer-width helper
// and a level type sized for the default depth.
package stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 4;

  // Pointer width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  typedef logic [$clog2(DEFAULT_DEPTH):0] level_t;

endpackage

// File: rtl/stream_fifo_ptr.sv
// Wrapping FIFO pointer: advances on inc, cleared by rst or clr.
module stream_fifo_ptr
  import stream_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         inc,
  output logic [clog2_min1(DEPTH)-1:0] ptr
);

  localparam int PTR_W = clog2_min1(DEPTH);

  logic [PTR_W-1:0] ptr_reg;

  // DEPTH is a power of two, so natural overflow gives the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= ptr_reg + PTR_W'(1);
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/stream_fifo.sv
// Parametrised valid/ready FIFO with fill level, flush and optional
// fall-through of beats arriving while empty.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int FALL_THROUGH = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [LVL_W-1:0]      count_reg;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic ft_beat;
  logic wr_en;
  logic rd_inc;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == LVL_W'(DEPTH));
  assign in_ready = ~full & ~flush;

  generate
    if (FALL_THROUGH != 0) begin : g_ft
      assign out_valid = ~empty | in_valid;
      assign out_data  = empty ? in_data : mem[rd_ptr];
      // A beat that bypasses storage leaves pointers and count untouched.
      assign ft_beat   = empty & in_valid & out_ready;
    end else begin : g_no_ft
      assign out_valid = ~empty;
      assign out_data  = mem[rd_ptr];
      assign ft_beat   = 1'b0;
    end
  endgenerate

  assign push   = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign wr_en  = push & ~ft_beat;
  assign rd_inc = pop & ~ft_beat;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  stream_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (wr_en),
    .ptr (wr_ptr)
  );

  stream_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (rd_inc),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_reg <= '0;
    end else begin
      case ({wr_en, rd_inc})
        2'b10:   count_reg <= count_reg + LVL_W'(1);
        2'b01:   count_reg <= count_reg - LVL_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign level = count_reg;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a registered instance (a_*) checked against
// a queue scoreboard, plus a fall-through instance (b_*) with direct checks.
module tb_stream_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       a_flush = 1'b0;
  logic [7:0] a_in_data = '0;
  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [7:0] a_out_data;
  logic       a_out_valid;
  logic       a_out_ready = 1'b0;
  logic [2:0] a_level;

  logic       b_flush = 1'b0;
  logic [7:0] b_in_data = '0;
  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [7:0] b_out_data;
  logic       b_out_valid;
  logic       b_out_ready = 1'b0;
  logic [2:0] b_level;

  int tests = 0;
  int fails = 0;
  logic [7:0] q[$];

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FALL_THROUGH(0)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .level(a_level)
  );

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FALL_THROUGH(1)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .level(b_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on dut_a: drive after negedge, check against the queue model,
  // then commit the model's handshake at the posedge.
  task automatic a_cycle(input logic iv, input logic [7:0] d, input logic ordy);
    logic mpush, mpop;
    a_in_valid  = iv;
    a_in_data   = d;
    a_out_ready = ordy;
    #1;
    chk("a_level", 32'(a_level), 32'(q.size()));
    chk("a_in_ready", 32'(a_in_ready), 32'(q.size() != 4));
    chk("a_out_valid", 32'(a_out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("a_out_data", 32'(a_out_data), 32'(q[0]));
    $display("[TB] a: iv=%0b d=%02h ordy=%0b level=%0d out_valid=%0b out_data=%02h",
             iv, d, ordy, a_level, a_out_valid, a_out_data);
    mpush = iv && (q.size() != 4);
    mpop  = ordy && (q.size() != 0);
    @(posedge clk);
    if (mpop) void'(q.pop_front());
    if (mpush) q.push_back(d);
    @(negedge clk);
  endtask

  task automatic a_idle_check;
    a_cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    // Reset held for two cycles.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    a_idle_check();
    #1;
    chk("b_reset_level", 32'(b_level), 32'd0);
    chk("b_reset_out_valid", 32'(b_out_valid), 32'd0);

    // Fill to full with the consumer stalled, then drain.
    a_cycle(1'b1, 8'h11, 1'b0);
    a_cycle(1'b1, 8'h22, 1'b0);
    a_cycle(1'b1, 8'h33, 1'b0);
    a_cycle(1'b1, 8'h44, 1'b0);
    for (int i = 0; i < 5; i++) a_cycle(1'b0, 8'h00, 1'b1);
    a_idle_check();

    // Three buffered beats, then streaming with wrap.
    for (int i = 0; i < 3; i++) a_cycle(1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 10; i++) a_cycle(1'b1, 8'(8'h63 + i), 1'b1);
    for (int i = 0; i < 4; i++) a_cycle(1'b0, 8'h00, 1'b1);

    // Backpressure at full: 0x55 refused until a slot frees.
    for (int i = 0; i < 4; i++) a_cycle(1'b1, 8'(8'h80 + i), 1'b0);
    a_cycle(1'b1, 8'h55, 1'b0);
    a_cycle(1'b1, 8'h55, 1'b1);
    a_cycle(1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 5; i++) a_cycle(1'b0, 8'h00, 1'b1);

    // Flush with two entries buffered.
    a_cycle(1'b1, 8'hC1, 1'b0);
    a_cycle(1'b1, 8'hC2, 1'b0);
    a_flush = 1'b1;
    a_in_valid = 1'b1;
    a_in_data = 8'hEE;
    a_out_ready = 1'b0;
    #1;
    chk("a_flush_in_ready", 32'(a_in_ready), 32'd0);
    @(posedge clk);
    q.delete();
    @(negedge clk);
    a_flush = 1'b0;
    a_idle_check();

    // Same scenario through reset.
    a_cycle(1'b1, 8'hD1, 1'b0);
    a_cycle(1'b1, 8'hD2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    a_idle_check();
    a_cycle(1'b1, 8'hD3, 1'b0);
    a_cycle(1'b0, 8'h00, 1'b1);
    a_idle_check();

    // Fall-through: empty FIFO forwards the beat in the same cycle.
    b_in_valid = 1'b1;
    b_in_data = 8'hA5;
    b_out_ready = 1'b1;
    #1;
    chk("b_ft_out_valid", 32'(b_out_valid), 32'd1);
    chk("b_ft_out_data", 32'(b_out_data), 32'hA5);
    chk("b_ft_level", 32'(b_level), 32'd0);
    $display("[TB] b: fall-through out_valid=%0b out_data=%02h level=%0d", b_out_valid, b_out_data, b_level);
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    chk("b_ft_after_level", 32'(b_level), 32'd0);
    chk("b_ft_after_out_valid", 32'(b_out_valid), 32'd0);

    // Fall-through with consumer stalled: beat is stored instead.
    b_in_valid = 1'b1;
    b_in_data = 8'h3C;
    b_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    chk("b_store_level", 32'(b_level), 32'd1);
    chk("b_store_out_valid", 32'(b_out_valid), 32'd1);
    chk("b_store_out_data", 32'(b_out_data), 32'h3C);
    $display("[TB] b: stored level=%0d out_data=%02h", b_level, b_out_data);
    b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_out_ready = 1'b0;
    #1;
    chk("b_drain_level", 32'(b_level), 32'd0);
    chk("b_drain_out_valid", 32'(b_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parametrised synchronous FIFO between two valid/ready streams.
- Next generation of the fixed 32-bit data/valid/ready bundle: payload width and depth are configurable; adds buffering, backpressure, fill level and flush.
- Sits between a stream producer and a stream consumer in one clock domain.
- Exercises parametrised storage arrays, counters and handshake logic through the frontend.

Parameters:
- DATA_WIDTH, 32, payload bits per beat (>=1).
- DEPTH, 4, number of entries (power of two, >=2).
- FALL_THROUGH, 0:
  - 1: when the FIFO is empty, an input beat is forwarded combinationally to the output in the same cycle.
  - 0: every beat passes through storage.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear of contents; active-high.
- in_data  in  DATA_WIDTH  input payload.
- in_valid  in  1  input beat offered.
- in_ready  out  1  FIFO accepts input beat.
- out_data  out  DATA_WIDTH  output payload (head entry).
- out_valid  out  1  output beat offered.
- out_ready  in  1  consumer accepts output beat.
- level  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.

Behaviour:
- Handshake terms:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - A beat transfers only on a rising edge where both valid and ready are high.
- Stream rules, both sides:
  - valid must not depend on ready.
  - Once out_valid is asserted, out_data and out_valid hold until pop.
- State: storage array mem[DEPTH]; rd_ptr and wr_ptr, each $clog2(DEPTH) bits wide; count register, $clog2(DEPTH)+1 bits wide.
- Reset (rst=1 at clock edge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Outputs: in_ready=1, out_valid=0, level=0.
  - out_data is don't-care while out_valid=0; the bench must not check it.
  - mem contents are not reset.
- flush=1 has the same effect as reset on pointers and count in that cycle.
  - in_ready is forced to 0 during flush, so no push occurs.
  - A pop during flush is permitted; the beat is still considered consumed.
- in_ready = (count != DEPTH) & ~flush. It is registered-state based, with no combinational path from out_ready.
- out_valid:
  - = (count != 0), or, when FALL_THROUGH=1 and count==0, = in_valid.
  - out_data = mem[rd_ptr], or in_data in the fall-through case.
- Fall-through beat (FALL_THROUGH=1, count==0, in_valid=1, out_ready=1): push and pop occur in the same cycle; nothing is written; pointers and count are unchanged.
- Normal push: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Normal pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push+pop, or on a fall-through beat.
- Latency:
  - FALL_THROUGH=0: a beat pushed at edge N is visible on out_* after edge N; minimum latency 1 cycle.
  - FALL_THROUGH=1 and empty: latency 0.
- Full (count==DEPTH):
  - in_ready=0; a pop frees one slot, and in_ready returns to 1 in the next cycle.
  - Simultaneous push+pop when full is impossible, because in_ready=0.
- Empty (count==0, FALL_THROUGH=0): out_valid=0; a push is visible on the next cycle.
- Ordering: strict FIFO, including across pointer wrap.
- level = count.
- Reset mid-transfer: pending beats are discarded; no output glitch beyond the reset cycle.

Decomposition:
- Package stream_pkg holds:
  - function clog2_min1(n), returning max(1, $clog2(n)).
  - a typedef for the level width helper.
  - localparams for default DATA_WIDTH/DEPTH.
- Sub-module stream_fifo_ptr #(DEPTH):
  - Inputs: clk, rst, clr, inc.
  - Output: ptr, a wrapping counter.
  - Instantiated twice, once for rd_ptr and once for wr_ptr.
- count and the storage array stay in stream_fifo.

Test Plan:
- Reset check: hold rst for 2 cycles -> in_ready=1, out_valid=0, level=0 on the first cycle after release.
- Fill, then drain (DEPTH=4, DATA_WIDTH=8, out_ready=0):
  - Push 0x11, 0x22, 0x33, 0x44 -> level=4, in_ready=0.
  - Then set out_ready=1 -> out_data sequence 0x11, 0x22, 0x33, 0x44 on consecutive cycles; level reaches 0 and out_valid=0.
- Wrap and simultaneous push/pop:
  - Push 3 beats, then hold in_valid=1 and out_ready=1 for 10 cycles with incrementing data.
  - Required: level stays 3; output is the input sequence delayed by 3 beats; pointers wrap with no loss.
- Backpressure at full:
  - Fill to 4; in_valid=1 with 0x55 while in_ready=0 -> 0x55 not stored.
  - Pop one -> 0x55 accepted the next cycle and emerges as the 4th beat after the pop.
- Fall-through (FALL_THROUGH=1, empty):
  - in_valid=1, in_data=0xA5, out_ready=1 -> out_valid=1, out_data=0xA5 in the same cycle; level stays 0.
  - With out_ready=0 instead -> beat stored; level=1 next cycle.
- Flush and reset mid-stream:
  - With level=2, assert flush for 1 cycle -> next cycle level=0, out_valid=0, in_ready=1.
  - Repeat using rst -> identical result.
